// File: rtl/mips_cache_fill.sv
// Purpose: fill and write-through engine that sits between the 4-way data cache and an Avalon-MM memory.
// Latency: fill word returned 2+N cycles after the miss (N = read waitrequest cycles); a store reaches the bus 1 cycle after capture.
// Backpressure: mem_waitrequest holds the active request; wr_busy stalls the CPU store. MIPS_CACHE_FILL_WRBUF_EN selects posted (defined) or blocking writes.
module mips_cache_fill #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byte_en,
  input  logic              stall,
  output logic [31:0]       data_in,
  output logic              data_valid,
  output logic              wr_busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FILL  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            state_q, state_d;
  logic              wb_full_q, wb_full_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [3:0]        wb_be_q, wb_be_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [31:0]       data_in_q, data_in_d;

  logic drain_done;
  logic capture;

  // Store acceptance: the buffered entry finishing this edge frees the slot only in posted mode.
  always_comb begin
    drain_done = (state_q == S_DRAIN) && !mem_waitrequest;
`ifdef MIPS_CACHE_FILL_WRBUF_EN
    wr_busy = write_en & ~stall & wb_full_q & ~drain_done;
`else
    wr_busy = wb_full_q;
`endif
    capture = write_en & ~stall & ~wr_busy;
  end

  // Next state, write buffer and fill data; drain always beats fill so stores reach memory before a later load.
  always_comb begin
    state_d     = state_q;
    wb_full_d   = wb_full_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_be_d     = wb_be_q;
    fill_addr_d = fill_addr_q;
    data_in_d   = data_in_q;

    case (state_q)
      S_IDLE: begin
        // A store captured this edge goes straight to the bus next cycle.
        if (wb_full_q || capture) begin
          state_d = S_DRAIN;
        end else if (stall && (read_en || write_en)) begin
          fill_addr_d = addr & WORD_MASK;
          state_d     = S_FILL;
        end
      end
      S_DRAIN: begin
        if (!mem_waitrequest) begin
          wb_full_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_FILL: begin
        if (!mem_waitrequest) begin
          data_in_d = mem_readdata;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A capture on the drain-complete edge refills the slot: set wins over clear.
    if (capture) begin
      wb_full_d = 1'b1;
      wb_addr_d = addr & WORD_MASK;
      wb_data_d = writedata;
      wb_be_d   = byte_en;
    end
  end

  // State and datapath registers; reset abandons any bus transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wb_full_q   <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      wb_be_q     <= '0;
      fill_addr_q <= '0;
      data_in_q   <= '0;
    end else begin
      state_q     <= state_d;
      wb_full_q   <= wb_full_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_be_q     <= wb_be_d;
      fill_addr_q <= fill_addr_d;
      data_in_q   <= data_in_d;
    end
  end

  // Bus and cache outputs decode straight from state so they drop the moment reset asserts.
  always_comb begin
    mem_read       = (state_q == S_FILL);
    mem_write      = (state_q == S_DRAIN);
    mem_address    = (state_q == S_DRAIN) ? wb_addr_q : fill_addr_q;
    mem_writedata  = wb_data_q;
    mem_byteenable = wb_be_q;
    data_valid     = (state_q == S_RESP);
    data_in        = data_in_q;
  end

endmodule

// File: tb/tb_mips_cache_fill.sv
module tb_mips_cache_fill;

`ifdef MIPS_CACHE_FILL_WRBUF_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        read_en, write_en;
  logic [31:0] writedata;
  logic [3:0]  byte_en;
  logic        stall;
  logic [31:0] data_in;
  logic        data_valid, wr_busy;
  logic [31:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  logic rd_acc_prev = 1'b0;

  // Expected stores in commit order: {word addr, data, lanes}.
  logic [67:0] exp_q[$];
  // Memory as seen by the slave, and as the CPU believes it to be.
  logic [31:0] mem_m  [logic [31:0]];
  logic [31:0] view_m [logic [31:0]];

  mips_cache_fill #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .read_en(read_en), .write_en(write_en),
    .writedata(writedata), .byte_en(byte_en), .stall(stall),
    .data_in(data_in), .data_valid(data_valid), .wr_busy(wr_busy),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : dflt(a);
  endfunction

  function automatic logic [31:0] view_rd(input logic [31:0] a);
    return view_m.exists(a) ? view_m[a] : dflt(a);
  endfunction

  // Bus monitor and memory slave: stores must reach memory in commit order, fills follow their accept by one cycle.
  always @(negedge clk) begin
    logic [67:0] e;
    if (rst) begin
      if (mem_read || mem_write) check("rw_excl", {31'd0, mem_read & mem_write}, 32'd0);
      if (data_valid) check("dv_lat", {31'd0, rd_acc_prev}, 32'd1);
      if (write_en && !stall && !wr_busy)
        exp_q.push_back({addr & 32'hFFFF_FFFC, writedata, byte_en});
      if (mem_write && !mem_waitrequest) begin
        if (exp_q.size() == 0) begin
          check("wr_unexp", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_address, e[67:36]);
          check("wr_data", mem_writedata, e[35:4]);
          check("wr_be", {28'd0, mem_byteenable}, {28'd0, e[3:0]});
          mem_m[e[67:36]] = merge(slave_rd(e[67:36]), e[35:4], e[3:0]);
        end
        wr_cnt++;
      end
      rd_acc_prev = mem_read & !mem_waitrequest;
    end else begin
      rd_acc_prev = 1'b0;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Random slave behaviour for the next cycle.
  task automatic rbus();
    mem_waitrequest = ($urandom_range(0, 3) == 0);
    mem_readdata    = slave_rd(mem_address);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 30) begin
      smp(); nxt(); k++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    smp(); nxt();
  endtask

  initial begin
    int k, wc0, op;
    logic acc;
    logic [31:0] r2, a, d, ex;

    rst = 1'b0; addr = '0; read_en = 0; write_en = 0; writedata = '0; byte_en = '0;
    stall = 0; mem_waitrequest = 0; mem_readdata = '0;

    // Reset state
    #3;
    check("rst_rd", {31'd0, mem_read}, 32'd0);
    check("rst_wr", {31'd0, mem_write}, 32'd0);
    check("rst_dv", {31'd0, data_valid}, 32'd0);
    check("rst_din", data_in, 32'd0);
    check("rst_adr", mem_address, 32'd0);
    check("rst_busy", {31'd0, wr_busy}, 32'd0);
    smp(); nxt(); smp(); nxt();
    rst = 1'b1;
    smp(); nxt();

    // Read miss, no wait states
    addr = 32'h40; stall = 1; read_en = 1; mem_waitrequest = 0; mem_readdata = 32'hDEADBEEF;
    smp(); check("t1_c0_rd", {31'd0, mem_read}, 32'd0); nxt();
    smp(); check("t1_c1_rd", {31'd0, mem_read}, 32'd1);
    check("t1_c1_adr", mem_address, 32'h40);
    check("t1_c1_dv", {31'd0, data_valid}, 32'd0); nxt();
    smp(); check("t1_c2_dv", {31'd0, data_valid}, 32'd1);
    check("t1_c2_din", data_in, 32'hDEADBEEF);
    check("t1_c2_rd", {31'd0, mem_read}, 32'd0); nxt();
    stall = 0; read_en = 0; mem_readdata = '0;
    smp(); check("t1_c3_dv", {31'd0, data_valid}, 32'd0);
    check("t1_hold", data_in, 32'hDEADBEEF); nxt();

    // Read miss, 3 wait cycles, unaligned address changed during fill
    r2 = $urandom;
    addr = 32'h107; stall = 1; read_en = 1; mem_waitrequest = 1; mem_readdata = r2;
    smp(); nxt();
    for (int c = 1; c <= 4; c++) begin
      if (c >= 2) addr = 32'h999;
      if (c == 4) mem_waitrequest = 0;
      smp();
      check($sformatf("t2_c%0d_rd", c), {31'd0, mem_read}, 32'd1);
      check($sformatf("t2_c%0d_adr", c), mem_address, 32'h104);
      check($sformatf("t2_c%0d_dv", c), {31'd0, data_valid}, 32'd0);
      nxt();
    end
    smp(); check("t2_c5_dv", {31'd0, data_valid}, 32'd1);
    check("t2_c5_din", data_in, r2); nxt();
    stall = 0; read_en = 0; addr = 0;
    smp(); check("t2_c6_dv", {31'd0, data_valid}, 32'd0); nxt();

    // Single store hit
    addr = 32'h20; write_en = 1; writedata = 32'h12345678; byte_en = 4'b0011; mem_waitrequest = 0;
    smp(); check("t3_c0_busy", {31'd0, wr_busy}, 32'd0); nxt();
    write_en = 0;
    smp(); check("t3_c1_wr", {31'd0, mem_write}, 32'd1);
    check("t3_c1_adr", mem_address, 32'h20);
    check("t3_c1_wd", mem_writedata, 32'h12345678);
    check("t3_c1_be", {28'd0, mem_byteenable}, 32'h3);
    check("t3_c1_busy", {31'd0, wr_busy}, {31'd0, !POSTED}); nxt();
    smp(); check("t3_c2_wr", {31'd0, mem_write}, 32'd0);
    check("t3_c2_busy", {31'd0, wr_busy}, 32'd0); nxt();

    // Back-to-back stores against a slow slave
    addr = 32'h24; write_en = 1; writedata = 32'hAAAA0001; byte_en = 4'hF; mem_waitrequest = 1;
    smp(); check("t4_c0_busy", {31'd0, wr_busy}, 32'd0); nxt();
    addr = 32'h28; writedata = 32'hBBBB0002; byte_en = 4'hC;
    smp(); check("t4_c1_wr", {31'd0, mem_write}, 32'd1);
    check("t4_c1_adr", mem_address, 32'h24);
    check("t4_c1_busy", {31'd0, wr_busy}, 32'd1); nxt();
    smp(); check("t4_c2_busy", {31'd0, wr_busy}, 32'd1); nxt();
    mem_waitrequest = 0;
    smp(); check("t4_c3_adr", mem_address, 32'h24);
    check("t4_c3_busy", {31'd0, wr_busy}, {31'd0, !POSTED});
    k = 0;
    while (wr_busy && k < 10) begin
      nxt(); smp(); k++;
    end
    check("t4_b_acc", {31'd0, wr_busy}, 32'd0);
    nxt();
    write_en = 0;
    wait_drain("t4_drain");

    // Pending store then read miss to the same word: write must finish first
    addr = 32'h30; write_en = 1; writedata = 32'h5555AAAA; byte_en = 4'hF; mem_waitrequest = 1;
    smp(); check("t5_c0_busy", {31'd0, wr_busy}, 32'd0); nxt();
    write_en = 0; stall = 1; read_en = 1; mem_readdata = 32'h0BADF00D;
    wc0 = wr_cnt;
    k = 1;
    mem_waitrequest = 1;
    while (k < 20) begin
      smp();
      if (mem_read) break;
      nxt(); k++;
      mem_waitrequest = (k < 3);
    end
    check("t5_rd_seen", {31'd0, mem_read}, 32'd1);
    check("t5_order", 32'(wr_cnt), 32'(wc0 + 1));
    check("t5_adr", mem_address, 32'h30);
    nxt(); mem_waitrequest = 0;
    k = 0;
    smp();
    while (!data_valid && k < 10) begin
      nxt(); smp(); k++;
    end
    check("t5_dv", {31'd0, data_valid}, 32'd1);
    check("t5_din", data_in, 32'h0BADF00D);
    nxt(); stall = 0; read_en = 0;
    smp(); nxt();

    // Reset during fill wait, then a fresh miss
    addr = 32'h50; stall = 1; read_en = 1; mem_waitrequest = 1;
    smp(); nxt();
    smp(); check("t6_fill", {31'd0, mem_read}, 32'd1); nxt();
    rst = 0;
    #1;
    check("t6_rd_drop", {31'd0, mem_read}, 32'd0);
    check("t6_wr_drop", {31'd0, mem_write}, 32'd0);
    stall = 0; read_en = 0;
    for (int c = 0; c < 3; c++) begin
      smp(); check("t6_no_dv", {31'd0, data_valid}, 32'd0); nxt();
    end
    rst = 1;
    smp(); check("t6_no_dv2", {31'd0, data_valid}, 32'd0); nxt();
    addr = 32'h84; stall = 1; read_en = 1; mem_waitrequest = 0; mem_readdata = 32'hCAFEF00D;
    smp(); nxt();
    smp(); check("t6_rd", {31'd0, mem_read}, 32'd1);
    check("t6_adr", mem_address, 32'h84); nxt();
    smp(); check("t6_dv", {31'd0, data_valid}, 32'd1);
    check("t6_din", data_in, 32'hCAFEF00D); nxt();
    stall = 0; read_en = 0;
    smp(); nxt();

    // Random stores and loads over a small window: every load must see all earlier stores
    rbus();
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        a = 32'h1000 + 4 * $urandom_range(0, 15);
        d = $urandom;
        addr = a; writedata = d; byte_en = 4'($urandom_range(1, 15)); write_en = 1; stall = 0; read_en = 0;
        acc = 0;
        for (int j = 0; j < 60; j++) begin
          smp();
          if (!wr_busy) begin acc = 1; break; end
          nxt(); rbus();
        end
        check("rs_acc", {31'd0, acc}, 32'd1);
        view_m[a] = merge(view_rd(a), d, byte_en);
        nxt(); write_en = 0; rbus();
      end else if (op == 1) begin
        a = 32'h1000 + $urandom_range(0, 63);
        addr = a; stall = 1; read_en = 1; write_en = 0;
        ex = view_rd(a & 32'hFFFF_FFFC);
        acc = 0;
        for (int j = 0; j < 80; j++) begin
          smp();
          if (data_valid) begin acc = 1; break; end
          nxt(); rbus();
        end
        check("rl_dv", {31'd0, acc}, 32'd1);
        check("rl_data", data_in, ex);
        nxt(); stall = 0; read_en = 0; rbus();
        smp(); check("rl_dv_once", {31'd0, data_valid}, 32'd0);
        nxt(); rbus();
      end else begin
        smp(); nxt(); rbus();
      end
    end
    mem_waitrequest = 0;
    wait_drain("r_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
